clock_display_scan: RTL and testbench
=====================================

Name: clock_display_scan

Overview:
- Downstream consumer of the hour/min/sec counter block (`count_hour`, `count_min`, `count_sec`).
- Converts the three 6-bit binary values to BCD and drives a 6-digit, time-multiplexed, common-anode seven-segment display.
- Takes a tear-free snapshot of the time once per scan frame. This prevents a counter rollover in mid-frame from showing mixed digits.

Parameters:
- SCAN_DIV, 1000, number of clock cycles each digit stays lit. Legal range is 2..65535.

Ports:
- clock  input  1  system clock
- reset_n  input  1  reset, asynchronous, active-low
- enable  input  1  display enable. When 0, the display is blanked and the scan restarts.
- count_sec  input  6  seconds value from the counter block, binary
- count_min  input  6  minutes value, binary
- count_hour  input  6  hours value, binary
- seg_n  output  7  segment drive, active-low, bit order {g,f,e,d,c,b,a}
- dp_n  output  1  decimal point, active-low
- an_n  output  6  digit select, active-low, one-hot-low. Bit i selects digit i.
- frame_tick  output  1  one-cycle pulse when a new frame begins, i.e. when the snapshot is loaded

Behaviour:
- Reset state, asynchronous on reset_n low:
  - prescaler p=0, digit index idx=5, snapshot=0
  - an_n=6'b111111, seg_n=7'b1111111, dp_n=1, frame_tick=0
- Prescaler:
  - While enable=1, p increments every cycle.
  - When p==SCAN_DIV-1, p wraps to 0 and an internal tick is generated.
- Digit advance and snapshot:
  - On each tick, idx advances 0→1→…→5→0.
  - On the tick that moves idx 5→0, snapshot <= {count_hour, count_min, count_sec} and frame_tick=1 for that cycle.
- Output register:
  - an_n, seg_n and dp_n are registered from the current idx and snapshot.
  - Latency is one cycle: outputs change on the cycle after the tick.
- Startup timing: after reset release with enable=1:
  - The first tick occurs SCAN_DIV cycles after release.
  - Digit 0 is driven on the following cycle.
- Digit map:
  - 0 = sec ones, 1 = sec tens
  - 2 = min ones, 3 = min tens
  - 4 = hour ones, 5 = hour tens
- dp_n is 0 while digit 2 or digit 4 is lit (hh.mm.ss separators), and 1 otherwise.
- BCD conversion and range:
  - tens = v/10 (0..6), ones = v%10.
  - Out-of-range inputs (60..63) are displayed literally, with no clamping (63 shows "63").
- Segment codes for 0-9 use standard a-g encoding. Any unused code drives blank.
- enable=0:
  - p=0, idx=5, an_n all 1s and seg_n all 1s from the next cycle onward.
  - The snapshot is held.
  - When enable returns to 1, the scan restarts exactly as after reset: the first tick is after SCAN_DIV cycles, with a fresh snapshot.
- Inputs changing mid-frame have no effect until the next 5→0 tick.
- When a tick and enable falling occur in the same cycle, the enable behaviour takes priority.
- Reset asserted mid-frame returns all state to reset values immediately (asynchronously).

Optional Feature:
- Macro: LEAD_ZERO_BLANK_EN.
- Defined: when the hour tens digit is 0, digit 5 is blanked (seg_n=7'b1111111, an_n still selects it). All other digits are unaffected.
- Undefined: digit 5 always shows its value, including "0".

Decomposition:
- Package clock_disp_pkg holds:
  - segment constants SEG_0..SEG_9 and SEG_BLANK (7-bit active-low)
  - digit index constants DIG_SEC_ONES..DIG_HOUR_TENS
  - NUM_DIGITS=6
- Sub-module bin6_to_bcd (combinational, 6-bit in → 4-bit tens, 4-bit ones), instantiated three times.
- The top level owns the prescaler, idx, snapshot and output register.

Test Plan (SCAN_DIV=4):
- Reset held, then released with enable=1 and inputs 12:34:56:
  - Outputs stay blank for 4 cycles.
  - On cycle 5: an_n=6'b111110, seg_n=SEG_6, frame_tick pulses on the load cycle.
- Steady scan of 12:34:56 over one full frame:
  - Digit sequence 6,5,4,3,2,1 on an_n bits 0..5, each digit lit 4 cycles.
  - dp_n=0 only on digits 2 and 4.
- Change count_sec 56→57 while digit 2 is lit:
  - Digits 0-1 continue to show "56" until the next frame_tick, then show "57".
- Inputs 63:60:09:
  - Display shows "63", "60", "09" with no clamping.
  - With LEAD_ZERO_BLANK_EN and hour=05, digit 5 shows blank.
- Drop enable while digit 3 is lit:
  - Next cycle: an_n=6'b111111.
  - Re-enable: blank for 4 cycles, then digit 0 shows the new snapshot.
- Assert reset_n=0 asynchronously mid-digit (between clock edges):
  - an_n=6'b111111, seg_n=7'b1111111, dp_n=1 immediately, without a clock edge.

Source files
------------

// File: rtl/clock_display_scan_pkg.sv
// -----------------------------------------------------------------------------
// clock_disp_pkg
//   Shared constants for the clock display scanner:
//     - NUM_DIGITS        : number of multiplexed digits (hh mm ss)
//     - SEG_0..SEG_9      : active-low seven-segment codes, bit order {g,f,e,d,c,b,a}
//     - SEG_BLANK         : all segments off
//     - DIG_*             : digit index of each display position
//     - seg_encode()      : BCD digit to segment code, blank for 10..15
// -----------------------------------------------------------------------------
package clock_disp_pkg;

    localparam int NUM_DIGITS = 6;

    // Active-low segment codes {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [2:0] DIG_SEC_ONES  = 3'd0;
    localparam logic [2:0] DIG_SEC_TENS  = 3'd1;
    localparam logic [2:0] DIG_MIN_ONES  = 3'd2;
    localparam logic [2:0] DIG_MIN_TENS  = 3'd3;
    localparam logic [2:0] DIG_HOUR_ONES = 3'd4;
    localparam logic [2:0] DIG_HOUR_TENS = 3'd5;

    function automatic logic [6:0] seg_encode(input logic [3:0] i_d);
        logic [6:0] r;
        case (i_d)
            4'd0:    r = SEG_0;
            4'd1:    r = SEG_1;
            4'd2:    r = SEG_2;
            4'd3:    r = SEG_3;
            4'd4:    r = SEG_4;
            4'd5:    r = SEG_5;
            4'd6:    r = SEG_6;
            4'd7:    r = SEG_7;
            4'd8:    r = SEG_8;
            4'd9:    r = SEG_9;
            default: r = SEG_BLANK;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/clock_display_scan_bin6_to_bcd.sv
// -----------------------------------------------------------------------------
// bin6_to_bcd
//   Combinational 6-bit binary to two BCD digits. Covers the full 0..63
//   input range, so 60..63 come out as tens=6 with no clamping.
//   Ports:
//     i_bin  [5:0] : binary value
//     o_tens [3:0] : i_bin / 10 (0..6)
//     o_ones [3:0] : i_bin % 10
// -----------------------------------------------------------------------------
module bin6_to_bcd (
    input  logic [5:0] i_bin,
    output logic [3:0] o_tens,
    output logic [3:0] o_ones
);

    logic [5:0] w_sub;

    // Threshold chain is cheaper than a real divider for a 6-bit input
    always_comb begin
        o_tens = 4'd0;
        w_sub  = 6'd0;
        if (i_bin >= 6'd60) begin
            o_tens = 4'd6; w_sub = 6'd60;
        end else if (i_bin >= 6'd50) begin
            o_tens = 4'd5; w_sub = 6'd50;
        end else if (i_bin >= 6'd40) begin
            o_tens = 4'd4; w_sub = 6'd40;
        end else if (i_bin >= 6'd30) begin
            o_tens = 4'd3; w_sub = 6'd30;
        end else if (i_bin >= 6'd20) begin
            o_tens = 4'd2; w_sub = 6'd20;
        end else if (i_bin >= 6'd10) begin
            o_tens = 4'd1; w_sub = 6'd10;
        end
        o_ones = 4'(i_bin - w_sub);
    end

endmodule

// File: rtl/clock_display_scan.sv
// -----------------------------------------------------------------------------
// clock_display_scan
//   Scans hh:mm:ss from the counter block onto a 6-digit common-anode
//   seven-segment display. The time is snapshotted once per frame (on the
//   digit 5 -> 0 step) so a counter rollover mid-frame never shows mixed digits.
//
//   Parameter:
//     SCAN_DIV   : clock cycles each digit stays lit (2..65535)
//   Ports:
//     clock      : system clock
//     reset_n    : asynchronous active-low reset
//     enable     : 0 blanks the display and restarts the scan
//     count_sec  : seconds, binary
//     count_min  : minutes, binary
//     count_hour : hours, binary
//     seg_n      : segments {g,f,e,d,c,b,a}, active-low (registered)
//     dp_n       : decimal point, active-low, lit on digits 2 and 4 (registered)
//     an_n       : digit select, one-hot-low, bit i = digit i (registered)
//     frame_tick : high in the cycle whose closing edge loads the snapshot
//
//   Optional build macro:
//     LEAD_ZERO_BLANK_EN : blank digit 5 when the hour tens digit is 0
// -----------------------------------------------------------------------------
module clock_display_scan
    import clock_disp_pkg::*;
#(
    parameter int SCAN_DIV = 1000
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [5:0]            count_sec,
    input  logic [5:0]            count_min,
    input  logic [5:0]            count_hour,
    output logic [6:0]            seg_n,
    output logic                  dp_n,
    output logic [NUM_DIGITS-1:0] an_n,
    output logic                  frame_tick
);

    localparam logic [15:0] P_LAST = 16'(SCAN_DIV - 1);

    logic [15:0] r_p;
    logic [2:0]  r_idx;
    logic [17:0] r_snap;

    logic        w_tick;
    logic        w_wrap;
    logic [2:0]  w_idx_nxt;
    logic [17:0] w_snap_nxt;

    logic [3:0]  w_sec_tens,  w_sec_ones;
    logic [3:0]  w_min_tens,  w_min_ones;
    logic [3:0]  w_hour_tens, w_hour_ones;

    logic [3:0]            w_digit;
    logic [6:0]            w_seg;
    logic                  w_dp;
    logic [NUM_DIGITS-1:0] w_an;

    // Gating with enable gives the enable-low path priority over a tick
    assign w_tick     = enable && (r_p == P_LAST);
    assign w_wrap     = w_tick && (r_idx == DIG_HOUR_TENS);
    assign w_idx_nxt  = (r_idx == DIG_HOUR_TENS) ? DIG_SEC_ONES : r_idx + 3'd1;
    assign w_snap_nxt = w_wrap ? {count_hour, count_min, count_sec} : r_snap;
    assign frame_tick = w_wrap;

    // Decode the post-tick snapshot so the output register shows digit 0 of
    // the new frame on the same edge that loads it (one-cycle latency).
    bin6_to_bcd u_bcd_sec (
        .i_bin  (w_snap_nxt[5:0]),
        .o_tens (w_sec_tens),
        .o_ones (w_sec_ones)
    );

    bin6_to_bcd u_bcd_min (
        .i_bin  (w_snap_nxt[11:6]),
        .o_tens (w_min_tens),
        .o_ones (w_min_ones)
    );

    bin6_to_bcd u_bcd_hour (
        .i_bin  (w_snap_nxt[17:12]),
        .o_tens (w_hour_tens),
        .o_ones (w_hour_ones)
    );

    always_comb begin
        w_digit = 4'hF;
        w_dp    = 1'b1;
        case (w_idx_nxt)
            DIG_SEC_ONES:  w_digit = w_sec_ones;
            DIG_SEC_TENS:  w_digit = w_sec_tens;
            DIG_MIN_ONES:  begin w_digit = w_min_ones;  w_dp = 1'b0; end
            DIG_MIN_TENS:  w_digit = w_min_tens;
            DIG_HOUR_ONES: begin w_digit = w_hour_ones; w_dp = 1'b0; end
            DIG_HOUR_TENS: w_digit = w_hour_tens;
            default:       w_digit = 4'hF;
        endcase

        w_seg = seg_encode(w_digit);
`ifdef LEAD_ZERO_BLANK_EN
        if ((w_idx_nxt == DIG_HOUR_TENS) && (w_hour_tens == 4'd0))
            w_seg = SEG_BLANK;
`endif
        w_an = ~(NUM_DIGITS'(1) << w_idx_nxt);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_p        <= '0;
            r_idx      <= DIG_HOUR_TENS;
            r_snap     <= '0;
            an_n       <= '1;
            seg_n      <= SEG_BLANK;
            dp_n       <= 1'b1;
        end else if (!enable) begin
            // idx parked at 5 so the first tick after re-enable starts a frame
            r_p        <= '0;
            r_idx      <= DIG_HOUR_TENS;
            an_n       <= '1;
            seg_n      <= SEG_BLANK;
            dp_n       <= 1'b1;
        end else begin
            r_p <= (r_p == P_LAST) ? 16'd0 : r_p + 16'd1;
            if (w_tick) begin
                r_idx <= w_idx_nxt;
                an_n  <= w_an;
                seg_n <= w_seg;
                dp_n  <= w_dp;
            end
            if (w_wrap)
                r_snap <= w_snap_nxt;
        end
    end

endmodule

// File: tb/tb_clock_display_scan.sv
// -----------------------------------------------------------------------------
// tb_clock_display_scan
//   Directed bench for clock_display_scan with SCAN_DIV=4. Outputs are
//   sampled on the falling edge; expected segment codes are written out here.
// -----------------------------------------------------------------------------
module tb_clock_display_scan;

    localparam int SCAN_DIV = 4;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       enable;
    logic [5:0] count_sec, count_min, count_hour;
    logic [6:0] seg_n;
    logic       dp_n;
    logic [5:0] an_n;
    logic       frame_tick;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    clock_display_scan #(.SCAN_DIV(SCAN_DIV)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .enable     (enable),
        .count_sec  (count_sec),
        .count_min  (count_min),
        .count_hour (count_hour),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .an_n       (an_n),
        .frame_tick (frame_tick)
    );

    // Active-low {g,f,e,d,c,b,a}; 4'hF means blank
    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clock);
            @(negedge clock);
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // k<0 means fully blank display
    task automatic chk_dig(input string tag, input int k, input logic [3:0] d);
        logic [5:0] ean;
        logic [6:0] eseg;
        logic       edp;
        if (k < 0) begin
            ean = 6'h3F; eseg = 7'h7F; edp = 1'b1;
        end else begin
            ean  = ~(6'd1 << k);
            eseg = seg_of(d);
            edp  = (k == 2 || k == 4) ? 1'b0 : 1'b1;
        end
        chk({tag, "_an"},  16'(an_n),  16'(ean));
        chk({tag, "_seg"}, 16'(seg_n), 16'(eseg));
        chk({tag, "_dp"},  16'(dp_n),  16'(edp));
    endtask

    // Starts on digit 0 of a frame; ends on the first cycle of digit 5
    task automatic chk_frame(input string tag, input logic [5:0][3:0] fr);
        for (int k = 0; k < 6; k++) begin
            chk_dig($sformatf("%s_d%0d", tag, k), k, fr[k]);
            chk($sformatf("%s_ft%0d", tag, k), 16'(frame_tick), 16'd0);
            if (k < 5) cyc(4);
        end
    endtask

    initial begin
        logic [5:0][3:0] fr;
        logic [3:0]      h5_tens;

        reset_n    = 1'b0;
        enable     = 1'b1;
        count_hour = 6'd12;
        count_min  = 6'd34;
        count_sec  = 6'd56;
        cyc(2);
        chk_dig("rst", -1, 4'h0);
        chk("rst_ft", 16'(frame_tick), 16'd0);

        // Release between edges; three blank cycles then the load cycle
        reset_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            cyc(1);
            chk_dig($sformatf("start%0d", i), -1, 4'h0);
            chk($sformatf("start%0d_ft", i), 16'(frame_tick), 16'(i == 3));
        end
        cyc(1);

        // Full frame of 12:34:56, every cycle checked; seconds change mid-frame
        fr = {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
        for (int k = 0; k < 6; k++) begin
            for (int c = 0; c < 4; c++) begin
                chk_dig($sformatf("f1_d%0d_c%0d", k, c), k, fr[k]);
                chk($sformatf("f1_ft_d%0d_c%0d", k, c), 16'(frame_tick),
                    16'(k == 5 && c == 3));
                if (k == 2 && c == 0) count_sec = 6'd57;
                cyc(1);
            end
        end
        // New frame picks up 57
        chk_dig("f2_d0", 0, 4'd7);
        cyc(4);
        chk_dig("f2_d1", 1, 4'd5);

        // Out-of-range values shown literally: 63:60:09
        count_hour = 6'd63;
        count_min  = 6'd60;
        count_sec  = 6'd9;
        cyc(20);
        chk_frame("oor", {4'd6, 4'd3, 4'd6, 4'd0, 4'd0, 4'd9});

        // Hour 05: digit 5 blank only with leading-zero blanking
`ifdef LEAD_ZERO_BLANK_EN
        h5_tens = 4'hF;
`else
        h5_tens = 4'd0;
`endif
        count_hour = 6'd5;
        cyc(4);
        chk_frame("h05", {h5_tens, 4'd5, 4'd6, 4'd0, 4'd0, 4'd9});

        // Drop enable while digit 3 is lit
        cyc(16);
        chk_dig("pre_dis_d3", 3, 4'd6);
        cyc(1);
        enable = 1'b0;
        cyc(1);
        chk_dig("dis1", -1, 4'h0);
        chk("dis1_ft", 16'(frame_tick), 16'd0);
        cyc(2);
        chk_dig("dis3", -1, 4'h0);

        // Re-enable with new time 23:45:01
        count_hour = 6'd23;
        count_min  = 6'd45;
        count_sec  = 6'd1;
        enable     = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            cyc(1);
            chk_dig($sformatf("reen%0d", i), -1, 4'h0);
            chk($sformatf("reen%0d_ft", i), 16'(frame_tick), 16'(i == 3));
        end
        cyc(1);
        chk_dig("reen_d0", 0, 4'd1);
        cyc(4);
        chk_dig("reen_d1", 1, 4'd0);

        // Asynchronous reset between clock edges
        #2;
        reset_n = 1'b0;
        #1;
        chk_dig("arst", -1, 4'h0);
        chk("arst_ft", 16'(frame_tick), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
